// File: rtl/video_timing.sv
// Raster timing generator and pixel output stage: free-running hc/vc counters produce syncs,
// request pixels from the renderer and register the colour, blanked outside the visible area.
module video_timing #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 5,
    parameter int H_ACTIVE = 700,
    parameter int H_FRONT  = 19,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 3,
    parameter int V_ACTIVE = 500,
    parameter int V_FRONT  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic [9:0] px,
    output logic [8:0] py,
    output logic       req,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       de,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BACK + 2 * H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    // One spare code so the active-window end compares cleanly when the front porch is 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BACK + 2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BACK + V_ACTIVE);

    logic [HW-1:0] hc;
    logic [HW-1:0] hc_off;
    logic [VW-1:0] vc;
    logic [VW-1:0] vc_off;
    logic          hs_i;
    logic          vs_i;
    logic          hact;
    logic          vact;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    always_comb begin
        hs_i   = hc < H_SYNC_C;
        // vsync edges sit on the hsync falling edge so they never move while hsync is high.
        vs_i   = ((vc == '0) && (hc >= H_SYNC_C))
               || ((vc != '0) && (vc < V_SYNC_C))
               || ((vc == V_SYNC_C) && (hc < H_SYNC_C));
        hact   = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
        vact   = (vc >= V_ACT_BEG) && (vc < V_ACT_END);
        req    = hact && vact;
        hc_off = hc - H_ACT_BEG;
        vc_off = vc - V_ACT_BEG;
        px     = req ? 10'(hc_off >> 1) : '0;
        py     = req ? 9'(vc_off) : '0;
        frame_tick = (hc == '0) && (vc == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            de    <= 1'b0;
            rgb   <= '0;
        end else begin
            hsync <= hs_i;
            vsync <= vs_i;
            de    <= req;
            rgb   <= req ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing on a shrunken raster (15 clocks x 7 lines) so that
// several hundred frames, the frame counter wrap and a mid-frame reset fit in a short run.
`timescale 1ns/1ps
module tb_video_timing;
    localparam int HS = 4, HB = 2, HA = 3, HF = 3;
    localparam int VS = 2, VB = 1, VA = 2, VF = 2;
    // Hand-computed geometry for the parameters above.
    localparam int HT  = 15;
    localparam int FT  = 105;
    localparam int PIX = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rgb_in = 3'd0;
    logic [9:0] px;
    logic [8:0] py;
    logic       req, hsync, vsync, de, frame_tick;
    logic [2:0] rgb;
    logic [7:0] frame_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    bit         mon_en = 1'b0;
    bit         frame_open = 1'b0;
    bit         saw_wrap = 1'b0;
    int         mode = 0;
    int         pix_cnt = 0;
    // Output order per frame: row 0 cols 0..2 then row 1, each column held 2 clocks; value c^r.
    logic [2:0] pat_tab [PIX] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                                  3'd1, 3'd1, 3'd0, 3'd0, 3'd3, 3'd3};

    video_timing #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .px(px), .py(py), .req(req),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .de(de), .frame_tick(frame_tick),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: x = clocks since hsync fell, y = hsync rises since vsync rose.
    int         cyc, x, y, last_hs_rise, last_vs_rise, ticks;
    bit         hs_prev, vs_prev;
    logic [7:0] cnt_prev;
    logic [2:0] got;
    always @(negedge clk) begin
        if (!mon_en) begin
            cyc = 0; x = 999; y = -100; last_hs_rise = -1; last_vs_rise = -1;
            ticks = 0; hs_prev = 1'b0; vs_prev = 1'b0; cnt_prev = 8'd0;
        end else begin
            if (cyc <= 1) check("first hsync rise", hsync, (cyc == 1));
            if (hsync && !hs_prev) begin
                if (last_hs_rise >= 0) check("hsync period", cyc - last_hs_rise, HT);
                last_hs_rise = cyc;
                y++;
            end
            if (!hsync && hs_prev) begin
                check("hsync width", cyc - last_hs_rise, HS);
                x = 0;
            end else begin
                x++;
            end
            if (vsync != vs_prev) begin
                check("vsync edge hsync level", hsync, 0);
                check("vsync edge at hsync fall", x, 0);
            end
            if (vsync && !vs_prev) begin
                if (last_vs_rise >= 0) check("vsync period", cyc - last_vs_rise, FT);
                last_vs_rise = cyc;
                y = 0;
            end
            if (!vsync && vs_prev) check("vsync width", cyc - last_vs_rise, VS * HT);
            check("de window", de, (x >= HB) && (x < HB + 2 * HA) && (y >= VS + VB)
                                   && (y < VS + VB + VA));
            if (de) begin
                check("scoreboard nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("rgb pixel", rgb, got);
                end
                pix_cnt++;
            end else begin
                check("rgb blank", rgb, 0);
            end
            if (!req) begin
                check("px idle", px, 0);
                check("py idle", py, 0);
            end
            check("frame_tick", frame_tick, (cyc % FT) == 0);
            check("frame_cnt", frame_cnt, ticks % 256);
            if (frame_tick) ticks++;
            if (cnt_prev == 8'd255 && frame_cnt == 8'd0) saw_wrap = 1'b1;
            cnt_prev = frame_cnt;
            hs_prev  = hsync;
            vs_prev  = vsync;
            cyc++;
        end
    end

    task automatic drive_rgb();
        if (mode == 1) rgb_in = 3'b111;
        else rgb_in = req ? (px[2:0] ^ py[2:0]) : 3'b101;
    endtask

    task automatic open_frame();
        if (frame_open) begin
            check("pixels per frame", pix_cnt, PIX);
            check("scoreboard drained", exp_q.size(), 0);
        end
        pix_cnt = 0;
        for (int i = 0; i < PIX; i++) exp_q.push_back((mode == 1) ? 3'b111 : pat_tab[i]);
        frame_open = 1'b1;
    endtask

    task automatic run_frames(input int n, input int m);
        mode = m;
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < FT; k++) begin
                @(negedge clk);
                if (k == 0) open_frame();
                drive_rgb();
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset      = 1'b0;
        mon_en     = 1'b1;
        frame_open = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " hsync"}, hsync, 0);
        check({tag, " vsync"}, vsync, 0);
        check({tag, " de"}, de, 0);
        check({tag, " rgb"}, rgb, 0);
        check({tag, " frame_cnt"}, frame_cnt, 0);
        check({tag, " frame_tick"}, frame_tick, 1);
        check({tag, " req"}, req, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        release_reset();
        run_frames(2, 0);
        run_frames(2, 1);
        run_frames(254, 0);

        // Partial frame, then asynchronous reset while pixels are streaming.
        mode = 0;
        for (int k = 0; k < 54; k++) begin
            @(negedge clk);
            if (k == 0) open_frame();
            drive_rgb();
        end
        check("de before mid reset", de, 1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_cleared("mid reset");
        repeat (3) @(posedge clk);
        exp_q.delete();
        pix_cnt = 0;
        release_reset();
        run_frames(2, 0);
        check("pixels last frame", pix_cnt, PIX);
        check("scoreboard final", exp_q.size(), 0);
        check("frame_cnt wrapped", saw_wrap, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
